// File: rtl/password_pkg.sv
// Shared definitions for the password sender and its verifier.
package password_pkg;

  localparam int unsigned DIGIT_W    = 10;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CODE_W     = BCD_W * NUM_DIGITS;
  localparam int unsigned STATUS_W   = 4;
  localparam int unsigned ATTEMPT_W  = 2;
  localparam int unsigned PHASE_W    = 4;

  localparam logic [STATUS_W-1:0] STATUS_DONE  = 4'd4;
  localparam logic [STATUS_W-1:0] STATUS_ERROR = 4'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    DRIVE     = 3'd2,
    GAP       = 3'd3,
    WAIT_RESP = 3'd4,
    REPORT    = 3'd5
  } state_t;

  // True when every BCD digit of the code is in 0..9.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (code[i*int'(BCD_W) +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/digit_onehot.sv
// BCD digit to one-hot digit-line decoder; out-of-range digits give all zero.
module digit_onehot
  import password_pkg::*;
(
  input  logic [BCD_W-1:0]   bcd,
  output logic [DIGIT_W-1:0] onehot
);

  // Decode one digit; values above 9 light no line.
  always_comb begin
    onehot = '0;
    if (bcd <= 4'd9) onehot = DIGIT_W'(1) << bcd;
  end

endmodule

// File: rtl/password_sender.sv
// Sends a four-digit BCD code to a verifier as one-hot digit pulses,
// waits for its verdict and retries on error or timeout.
module password_sender
  import password_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CODE_W-1:0]    code_in,
  input  logic [STATUS_W-1:0]  status_in,
  output logic [DIGIT_W-1:0]   Sw,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 bad_code,
  output logic [ATTEMPT_W-1:0] attempts
);

  localparam int unsigned WAIT_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;

  state_t                state, state_nxt;
  logic [CODE_W-1:0]     code_q, code_nxt;
  logic [1:0]            idx, idx_nxt;
  logic [PHASE_W-1:0]    cnt, cnt_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  busy_nxt, pass_nxt, fail_nxt, bad_nxt;
  logic [ATTEMPT_W-1:0]  att_nxt;
  logic [DIGIT_W-1:0]    sw_nxt;

  logic [1:0]            sel_idx;
  logic [BCD_W-1:0]      sel_digit;
  logic [DIGIT_W-1:0]    sel_onehot;

  // Digit that will be on Sw next cycle if the FSM is then in DRIVE.
  always_comb begin
    sel_idx = 2'd0;
    case (state)
      DRIVE:   sel_idx = idx;
      GAP:     sel_idx = idx + 2'd1;
      default: sel_idx = 2'd0;
    endcase
  end

  // Pick the nibble, most significant digit first.
  always_comb begin
    sel_digit = '0;
    case (sel_idx)
      2'd0: sel_digit = code_q[15:12];
      2'd1: sel_digit = code_q[11:8];
      2'd2: sel_digit = code_q[7:4];
      2'd3: sel_digit = code_q[3:0];
      default: sel_digit = '0;
    endcase
  end

  digit_onehot u_digit_onehot (
    .bcd    (sel_digit),
    .onehot (sel_onehot)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wait_nxt  = wait_cnt;
    busy_nxt  = busy;
    pass_nxt  = pass;
    fail_nxt  = fail;
    bad_nxt   = bad_code;
    att_nxt   = attempts;
    sw_nxt    = '0;

    case (state)
      IDLE: begin
        if (start) begin
          code_nxt  = code_in;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          bad_nxt   = 1'b0;
          att_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (!code_valid(code_q)) begin
          fail_nxt  = 1'b1;
          bad_nxt   = 1'b1;
          state_nxt = REPORT;
        end else begin
          att_nxt   = attempts + ATTEMPT_W'(1);
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          state_nxt = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt == PHASE_W'(HOLD_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + PHASE_W'(1);
        end
      end

      GAP: begin
        if (cnt == PHASE_W'(GAP_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (idx == 2'd3) begin
            wait_nxt  = '0;
            state_nxt = WAIT_RESP;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = DRIVE;
          end
        end else begin
          cnt_nxt = cnt + PHASE_W'(1);
        end
      end

      WAIT_RESP: begin
        if (status_in == STATUS_DONE) begin
          pass_nxt  = 1'b1;
          state_nxt = REPORT;
        end else if ((status_in == STATUS_ERROR) ||
                     (wait_cnt == WAIT_W'(RESP_TIMEOUT - 1))) begin
          if (attempts < ATTEMPT_W'(MAX_ATTEMPTS)) begin
            state_nxt = CHECK;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = REPORT;
          end
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      REPORT: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (state_nxt == DRIVE) sw_nxt = sel_onehot;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_q   <= '0;
      idx      <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      bad_code <= 1'b0;
      attempts <= '0;
      Sw       <= '0;
    end else begin
      state    <= state_nxt;
      code_q   <= code_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      busy     <= busy_nxt;
      pass     <= pass_nxt;
      fail     <= fail_nxt;
      bad_code <= bad_nxt;
      attempts <= att_nxt;
      Sw       <= sw_nxt;
    end
  end

endmodule

// File: doc/password_sender.md
PASSWORD_SENDER -- requirements
Module: password_sender

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, cycles each digit is driven on Sw (range 1..15).
REQ-002 Parameter GAP_CYCLES, default 1, all-zero cycles after each digit (range 1..15).
REQ-003 Parameter RESP_TIMEOUT, default 8, max cycles to wait for a verifier result per attempt.
REQ-004 Parameter MAX_ATTEMPTS, default 3, total attempts before reporting failure (range 1..3).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request to transmit code_in; sampled only in IDLE.
REQ-008 code_in  input  16  four BCD digits, [15:12] sent first, [3:0] last.
REQ-009 status_in  input  4  verifier status word.
REQ-010 Sw  output  10  one-hot digit lines to the verifier.
REQ-011 busy  output  1  high from accepted start until result reported.
REQ-012 pass  output  1  level; verifier reported DONE on the last attempt.
REQ-013 fail  output  1  level; attempts exhausted, timeout, or invalid code.
REQ-014 bad_code  output  1  level; fail was caused by a digit > 9.
REQ-015 attempts  output  2  number of attempts started for the current/last request.

Function
REQ-016 States SHALL be IDLE, CHECK, DRIVE, GAP, WAIT_RESP, REPORT.
REQ-017 IDLE: start=1 SHALL capture code_in, clear pass/fail/bad_code, set attempts=0, busy=1, go to CHECK.
REQ-018 CHECK (1 cycle): any digit > 9 SHALL set fail=1, bad_code=1, go to REPORT with Sw never nonzero; else attempts+1, digit index=0, go to DRIVE.
REQ-019 DRIVE: Sw SHALL equal 1<<digit[index] for exactly HOLD_CYCLES cycles, then GAP.
REQ-020 GAP: Sw SHALL be 0 for exactly GAP_CYCLES cycles; index<3 -> index+1, DRIVE; index=3 -> WAIT_RESP.
REQ-021 WAIT_RESP: Sw=0; status_in==STATUS_DONE SHALL set pass=1 and go to REPORT next cycle.
REQ-022 WAIT_RESP: status_in==STATUS_ERROR or RESP_TIMEOUT cycles elapsed SHALL retry via CHECK if attempts<MAX_ATTEMPTS, else set fail=1 and go to REPORT.
REQ-023 DONE and ERROR in the same cycle are impossible by encoding; DONE on the timeout cycle SHALL win.
REQ-024 REPORT (1 cycle): busy SHALL drop to 0 on the following cycle, return to IDLE; pass/fail/bad_code/attempts held until next accepted start.
REQ-025 start while busy=1 SHALL be ignored; code_in changes while busy SHALL not affect the transmission.
REQ-026 Sw SHALL be registered, never have more than one bit set, and be 0 in every state except DRIVE.
REQ-027 Latency: first digit on Sw 2 cycles after the start cycle; one attempt occupies 4*(HOLD_CYCLES+GAP_CYCLES) cycles before WAIT_RESP.

Reset
REQ-028 rst=1 SHALL on the next edge force IDLE, Sw=0, busy=0, pass=0, fail=0, bad_code=0, attempts=0, counters=0, regardless of state.
REQ-029 rst asserted mid-transmission SHALL abort it without any further nonzero Sw cycle; start in the same cycle as rst SHALL be ignored.

Structure
REQ-030 Shared package password_pkg SHALL hold the state enum, STATUS_DONE=4'd4, STATUS_ERROR=4'd5, and the 10-bit digit width constant, shared with the verifier.
REQ-031 One sub-module digit_onehot (4-bit BCD in, 10-bit one-hot out, all-zero for >9) SHALL be instantiated for Sw generation.

Verification
REQ-032 code_in=16'h2014, start at cycle 0 -> Sw=0x004 cycles 2-3, 0 at 4, 0x001 at 5-6, 0 at 7, 0x002 at 8-9, 0 at 10, 0x010 at 11-12, 0 at 13; status_in=4 at 15 -> pass=1, attempts=1, busy=0 at 17.
REQ-033 Same code, status_in=5 in WAIT_RESP of attempts 1 and 2, 4 in attempt 3 -> three full digit sequences, pass=1, attempts=3.
REQ-034 status_in held 0 -> three attempts each timing out after 8 cycles, fail=1, bad_code=0, attempts=3.
REQ-035 code_in=16'h2A14 -> fail=1, bad_code=1, attempts=0, Sw=0 throughout.
REQ-036 rst=1 during second digit's DRIVE -> Sw=0 and busy=0 next cycle, all outputs at reset values; start during busy ignored (attempts unchanged).
